riscv_multicycle_ctrl: RTL and testbench

- Multicycle RISC-V (RV32I subset) controller FSM.
- Drives a shared instruction/data memory datapath with an instruction register (IR), OldPC, Data and ALUOut registers.
- Adds a memory-ready stall handshake and a retired-instruction counter; the single-cycle control unit has neither.
- Sits beside the multicycle data path inside the next-generation core top.

---
 rtl/riscv_multicycle_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I-subset controller FSM with memory-ready stalls, retired-instruction
// counter and sticky illegal flag. Optional macro RV_MC_BRANCH_EXT_EN adds bne/blt/bge.
module riscv_multicycle_ctrl #(
    parameter int ALUCTRL_W     = 3,
    parameter int CNT_W         = 32,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 Zero,
    input  logic                 Lt,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic                 RegWrite,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 illegal,
    output logic [CNT_W-1:0]     instret,
    output logic [3:0]           state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(5);

    state_t               state, state_next;
    logic                 mem_ok;
    logic                 funct_ok, br_ok, br_taken, retire;
    logic [ALUCTRL_W-1:0] alu_funct, alu_ctrl;
    logic                 pc_we, mem_we, ir_we, reg_we, adr_src;
    logic [1:0]           result_src, alu_src_a, alu_src_b, imm_src;

    // With the handshake disabled every memory access completes in its first cycle.
    assign mem_ok = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            instret <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (retire)
                instret <= instret + CNT_W'(1);
            if (state_next == TRAP)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        funct_ok  = 1'b1;
        alu_funct = ALU_ADD;
        case (funct3)
            3'b000:  alu_funct = (state == EXECUTER && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_funct = ALU_SLT;
            3'b110:  alu_funct = ALU_OR;
            3'b111:  alu_funct = ALU_AND;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        br_ok    = 1'b0;
        br_taken = 1'b0;
        case (funct3)
            3'b000: begin br_ok = 1'b1; br_taken = Zero;  end
`ifdef RV_MC_BRANCH_EXT_EN
            3'b001: begin br_ok = 1'b1; br_taken = !Zero; end
            3'b100: begin br_ok = 1'b1; br_taken = Lt;    end
            3'b101: begin br_ok = 1'b1; br_taken = !Lt;   end
`endif
            default: ;
        endcase
    end

`ifndef RV_MC_BRANCH_EXT_EN
    logic unused_lt;
    assign unused_lt = Lt;
`endif

    // NOTE: every signal written here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_next = state;
        pc_we      = 1'b0;
        adr_src    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        imm_src    = 2'b00;
        alu_ctrl   = ALU_ADD;
        retire     = 1'b0;
        case (state)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ok) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
                case (op)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_R:              state_next = EXECUTER;
                    OP_I:              state_next = EXECUTEI;
                    OP_BR:             state_next = BRANCH;
                    OP_JAL:            state_next = JAL;
                    default:           state_next = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (op == OP_STORE) begin
                    imm_src    = 2'b01;
                    state_next = MEMWRITE;
                end else begin
                    state_next = MEMREAD;
                end
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ok)
                    state_next = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_we     = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mem_we  = 1'b1;
                if (mem_ok) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            EXECUTER, EXECUTEI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = (state == EXECUTEI) ? 2'b01 : 2'b00;
                alu_ctrl   = alu_funct;
                state_next = funct_ok ? ALUWB : TRAP;
            end
            ALUWB: begin
                reg_we     = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_ctrl  = ALU_SUB;
                if (br_ok) begin
                    pc_we      = br_taken;
                    retire     = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = TRAP;
                end
            end
            JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_we      = 1'b1;
                state_next = ALUWB;
            end
            TRAP: ;
            default: state_next = FETCH;
        endcase
    end

    // Reset overrides the strobes combinationally so an aborted instruction writes nothing.
    assign PCWrite    = pc_we  & ~reset;
    assign MemWrite   = mem_we & ~reset;
    assign IRWrite    = ir_we  & ~reset;
    assign RegWrite   = reg_we & ~reset;
    assign AdrSrc     = adr_src;
    assign ResultSrc  = result_src;
    assign ALUSrcA    = alu_src_a;
    assign ALUSrcB    = alu_src_b;
    assign ImmSrc     = imm_src;
    assign ALUControl = alu_ctrl;
    assign state_dbg  = state;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Randomized self-checking bench for riscv_multicycle_ctrl: a per-instruction model builds
// the expected cycle-by-cycle timeline (and the mem_ready pattern) from the opcode rules.
module tb_riscv_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5, Zero, Lt, mem_ready;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
    logic [31:0] instret;
    logic [3:0]  state_dbg;

    riscv_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Lt(Lt), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegWrite(RegWrite), .ALUControl(ALUControl), .illegal(illegal),
        .instret(instret), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    localparam int S_ADR = 16, S_PC = 8, S_MW = 4, S_IR = 2, S_RW = 1;

    typedef struct {
        int st;
        bit mr;
        int strb;
        int alu;
        int rsrc;
    } cyc_t;

    cyc_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_instret = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int st, input bit mr, input int strb, input int alu, input int rsrc);
        cyc_t r;
        r.st = st; r.mr = mr; r.strb = strb; r.alu = alu; r.rsrc = rsrc;
        q.push_back(r);
    endtask

    function automatic logic [31:0] strobes();
        return {27'b0, AdrSrc, PCWrite, MemWrite, IRWrite, RegWrite};
    endfunction

    function automatic bit br_valid(input logic [2:0] f3);
`ifdef RV_MC_BRANCH_EXT_EN
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5);
`else
        return f3 == 3'd0;
`endif
    endfunction

    function automatic bit br_taken(input logic [2:0] f3, input bit z, input bit lt);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return lt;
            3'd5:    return !lt;
            default: return 1'b0;
        endcase
    endfunction

    // Two reset cycles; strobes must already be zero before the first reset edge.
    task automatic do_reset();
        reset = 1'b1; op = 7'b0110011; mem_ready = 1'b1;
        @(negedge clk);
        check("rst_strobe_abort", {28'b0, PCWrite, MemWrite, IRWrite, RegWrite}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_strobes", {28'b0, PCWrite, MemWrite, IRWrite, RegWrite}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_instret = '0;
    endtask

    task automatic run_insn(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                            input bit z, input bit lt, input int sf, input int sm,
                            input int abort_at);
        bit retires = 1'b0;
        bit traps   = 1'b0;
        bit is_r;
        int alu;
        q.delete();
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; Lt = lt;
        for (int k = 0; k < sf; k++) push(0, 1'b0, 0, 0, 2);
        push(0, 1'b1, S_IR | S_PC, 0, 2);
        push(1, 1'($urandom), 0, 0, -1);
        case (o)
            7'b0000011, 7'b0100011: begin
                bit st = (o == 7'b0100011);
                push(2, 1'($urandom), 0, 0, -1);
                for (int k = 0; k < sm; k++) push(st ? 5 : 3, 1'b0, S_ADR | (st ? S_MW : 0), -1, -1);
                push(st ? 5 : 3, 1'b1, S_ADR | (st ? S_MW : 0), -1, -1);
                if (!st) push(4, 1'($urandom), S_RW, -1, 1);
                retires = 1'b1;
            end
            7'b0110011, 7'b0010011: begin
                is_r = (o == 7'b0110011);
                case (f3)
                    3'd0:    alu = (is_r && f7) ? 1 : 0;
                    3'd2:    alu = 5;
                    3'd6:    alu = 3;
                    3'd7:    alu = 2;
                    default: alu = -1;
                endcase
                push(is_r ? 6 : 7, 1'($urandom), 0, alu, -1);
                if (alu >= 0) begin
                    push(8, 1'($urandom), S_RW, -1, 0);
                    retires = 1'b1;
                end else traps = 1'b1;
            end
            7'b1100011: begin
                bit ok = br_valid(f3);
                push(9, 1'($urandom), (ok && br_taken(f3, z, lt)) ? S_PC : 0, 1, 0);
                if (ok) retires = 1'b1; else traps = 1'b1;
            end
            7'b1101111: begin
                push(10, 1'($urandom), S_PC, 0, 0);
                push(8, 1'($urandom), S_RW, -1, 0);
                retires = 1'b1;
            end
            default: traps = 1'b1;
        endcase
        if (traps) for (int k = 0; k < 3; k++) push(11, 1'($urandom), 0, -1, -1);

        check("instret_start", instret, exp_instret);
        foreach (q[i]) begin
            if (abort_at >= 0 && i == abort_at) begin
                do_reset();
                return;
            end
            mem_ready = q[i].mr;
            @(negedge clk);
            check("state", 32'(state_dbg), 32'(q[i].st));
            check("strobes", strobes(), 32'(q[i].strb));
            check("illegal", 32'(illegal), 32'(q[i].st == 11));
            if (q[i].alu >= 0)  check("alu_ctrl", 32'(ALUControl), 32'(q[i].alu));
            if (q[i].rsrc >= 0) check("result_src", 32'(ResultSrc), 32'(q[i].rsrc));
            @(posedge clk); #1;
        end
        if (retires) exp_instret = exp_instret + 32'd1;
        if (traps) begin
            @(negedge clk);
            check("trap_instret", instret, exp_instret);
            check("trap_illegal_held", 32'(illegal), 32'd1);
            do_reset();
        end
    endtask

    initial begin
        reset = 1'b1; op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0;
        Zero = 1'b0; Lt = 1'b0; mem_ready = 1'b1;
        do_reset();

        run_insn(7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, -1);   // add
        run_insn(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3, -1);   // lw, 3 stalls
        run_insn(7'b1100011, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0, -1);   // beq taken
        run_insn(7'b1100011, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, -1);   // beq not taken
        run_insn(7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0, 1, 0, -1);   // sub, fetch stall
        run_insn(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 0, 2, -1);   // sw, 2 stalls
        run_insn(7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, -1);   // jal
        run_insn(7'b0010011, 3'd6, 1'b1, 1'b0, 1'b0, 0, 0, -1);   // ori
        run_insn(7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, -1);   // illegal opcode
        run_insn(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 0, 2, 4);    // sw aborted in MEMWRITE
        run_insn(7'b0110011, 3'd7, 1'b0, 1'b0, 1'b0, 0, 0, -1);   // and
        run_insn(7'b1100011, 3'd4, 1'b0, 1'b0, 1'b1, 0, 0, -1);   // blt, Lt=1

        for (int n = 0; n < 300; n++) begin
            logic [6:0] o;
            logic [2:0] f3;
            int sel = $urandom_range(0, 15);
            f3 = 3'($urandom);
            if (sel <= 2)       o = 7'b0000011;
            else if (sel <= 4)  o = 7'b0100011;
            else if (sel <= 7)  o = 7'b0110011;
            else if (sel <= 10) o = 7'b0010011;
            else if (sel <= 13) o = 7'b1100011;
            else if (sel == 14) o = 7'b1101111;
            else                o = 7'b1110011;
            if ((o == 7'b0110011 || o == 7'b0010011) && $urandom_range(0, 9) != 0) begin
                case ($urandom_range(0, 3))
                    0: f3 = 3'd0;
                    1: f3 = 3'd2;
                    2: f3 = 3'd6;
                    default: f3 = 3'd7;
                endcase
            end
            if (o == 7'b1100011 && $urandom_range(0, 9) < 7) begin
                case ($urandom_range(0, 3))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            run_insn(o, f3, 1'($urandom), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end

        @(negedge clk);
        check("instret_final", instret, exp_instret);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
